// File: rtl/qa_drv_hc_pkg.sv
// Shared definitions for both ends of the host-channel issue protocol.
package qa_drv_hc_pkg;

    // Entries the receive FIFO reserves once almostfull rises. This must match the issue-side
    // gate depth: producer sampling flop plus issue pipeline.
    localparam int unsigned QA_HC_DEFAULT_SLACK      = 4;
    localparam int unsigned QA_HC_DEFAULT_DEPTH      = 32;
    localparam int unsigned QA_HC_DEFAULT_DATA_WIDTH = 64;

    // Pointer index for the default-depth receive FIFO.
    typedef logic [$clog2(QA_HC_DEFAULT_DEPTH)-1:0] t_qa_hc_fifo_idx;

    // Payload word carried on the channel.
    typedef logic [QA_HC_DEFAULT_DATA_WIDTH-1:0] t_qa_hc_payload;

    // True when v is a non-zero power of two.
    function automatic bit qa_hc_is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/qa_drv_hc_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents not reset.
module qa_drv_hc_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port: one entry per accepted write, no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port is combinational so the head entry is visible the cycle after it is written.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/qa_drv_hc_rx_almostfull_fifo.sv
// Receive-side FIFO for the host-channel issue protocol. Buffers producer writes for the
// consumer and drives a registered almostfull that leaves SLACK entries for in-flight writes.
module qa_drv_hc_rx_almostfull_fifo
    import qa_drv_hc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned SLACK      = QA_HC_DEFAULT_SLACK
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enq_en,
    input  logic [DATA_WIDTH-1:0]      enq_data,
    output logic                       almostfull,
    input  logic                       deq_en,
    output logic [DATA_WIDTH-1:0]      first,
    output logic                       not_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_CNT = CW'(DEPTH - SLACK);

    if (!qa_hc_is_pow2(DEPTH) || (DEPTH < 4) || (SLACK < 2) || (SLACK >= DEPTH))
    begin : g_param_check
        $fatal(1, "qa_drv_hc_rx_almostfull_fifo: DEPTH must be a power of 2 >= 4, 2 <= SLACK < DEPTH");
    end

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          not_empty_q, almostfull_q, overflow_q, underflow_q;
    logic          enq_acc, deq_acc;

    // Accept decisions. A full FIFO still takes a write when the head leaves on the same edge;
    // an empty FIFO never bypasses, so deq is refused even if a write arrives together.
    always_comb begin
        deq_acc = deq_en && (count_q != '0);
        enq_acc = enq_en && ((count_q < FULL_CNT) || deq_acc);
        count_d = count_q + {{(CW-1){1'b0}}, enq_acc} - {{(CW-1){1'b0}}, deq_acc};
    end

    // Pointers, occupancy and flags. Flags derive from count_d so they line up with count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            not_empty_q  <= 1'b0;
            almostfull_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (enq_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (deq_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q      <= count_d;
            not_empty_q  <= (count_d != '0);
            almostfull_q <= (count_d >= THRESH_CNT);
            if (enq_en && !enq_acc) begin
                overflow_q <= 1'b1;
            end
            if (deq_en && (count_q == '0)) begin
                underflow_q <= 1'b1;
            end
        end
    end

    qa_drv_hc_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (enq_acc),
        .waddr (wr_ptr_q),
        .wdata (enq_data),
        .raddr (rd_ptr_q),
        .rdata (first)
    );

    assign count      = count_q;
    assign not_empty  = not_empty_q;
    assign almostfull = almostfull_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
